rob_mw: RTL and testbench
=========================

Name: rob_mw

Overview:
- Parametrised multi-way reorder buffer; successor to the fixed 2-way ROB.
- Sits between rename/dispatch and the commit stage / free list. Receives completion and branch resolution from up to CDB_W result buses.
- Adds a dispatch ready handshake, per-lane ROB index return, old-PRN release on commit, and a single-cycle flush with redirect PC on a mispredicted branch.

Parameters:
- WAYS, 2, dispatch and commit lanes per cycle.
- CDB_W, 2, completion buses per cycle.
- DEPTH, 32, ROB entries; must be a power of 2 and at least 2*WAYS.
- XLEN, 32, PC/target width.
- AREGS, 32, architectural registers.
- PRF, 64, physical registers.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- disp_valid  in  WAYS  per-lane dispatch request; must be contiguous from lane 0.
- disp_ready  out  1  ROB accepts this cycle's dispatch group.
- disp_arn  in  WAYS x clog2(AREGS)  destination architectural register.
- disp_prn  in  WAYS x clog2(PRF)  new destination physical register.
- disp_old_prn  in  WAYS x clog2(PRF)  previous mapping of disp_arn.
- disp_reg_write, disp_is_branch, disp_pred_taken  in  WAYS each  per-lane flags.
- disp_pc, disp_pred_target  in  WAYS x XLEN  per-lane PC and predicted target.
- disp_rob_idx  out  WAYS x clog2(DEPTH)  entry allocated per lane (tail+i).
- cdb_valid, cdb_taken  in  CDB_W each  completion and resolved direction.
- cdb_rob_idx  in  CDB_W x clog2(DEPTH)  completing entry.
- cdb_target  in  CDB_W x XLEN  resolved target.
- commit_valid  out  WAYS  lane retires this cycle.
- commit_reg_write  out  WAYS  retiring lane writes a register.
- commit_arn, commit_prn, commit_old_prn  out  per-lane fields of the retiring entry.
- flush  out  1  mispredicted branch retired this cycle.
- redirect_pc  out  XLEN  fetch restart PC, valid while flush=1.
- num_free  out  clog2(DEPTH)+1  registered count of free entries.

Behaviour:
- Reset (async, reset_n=0):
  - head=tail=0, count=0, all entry valid/done bits=0.
  - commit_valid=0, flush=0, redirect_pc=0, num_free=DEPTH.
  - disp_ready=1 once reset_n deasserts.
- Entry fields: valid, done, arn, prn, old_prn, reg_write, is_branch, pred_taken, pc, pred_target, mispred.
- Dispatch:
  - disp_ready = (num_free >= WAYS) && !flush. Uses registered num_free only; same-cycle commits do not add capacity.
  - Group accepted when disp_ready=1. The n valid lanes write entries tail..tail+n-1 mod DEPTH with valid=1, done=0, mispred=0. Then tail += n.
  - disp_valid bits with disp_ready=0 are dropped; upstream holds them.
  - disp_rob_idx[i] = tail+i, combinational, valid regardless of ready.
- Completion (registered, one-cycle latency):
  - Each cdb lane with cdb_valid=1 and target entry valid=1 sets done=1.
  - For branches, mispred = (cdb_taken != pred_taken) || (cdb_taken && cdb_target != pred_target).
  - The entry also stores the resolved target: cdb_target if taken, else pc+4.
  - A CDB write to an invalid entry is ignored. Two CDB lanes on the same index: the higher lane wins.
- Commit (combinational from registered state):
  - Scan head..head+WAYS-1. Lane i retires iff the entry is valid and done and all lanes below it retire.
  - The scan stops after the first retiring mispred branch.
  - head += retired count. Retiring entries are cleared (valid=0) at the next edge.
- Flush:
  - flush=1 in the same cycle a mispred branch retires; redirect_pc = that entry's resolved target.
  - Next edge: head=tail=0, count=0, all valid=0; same-cycle dispatch and CDB updates are discarded.
  - Older lanes in the flush cycle still retire normally.
- Occupancy:
  - num_free_next = num_free - dispatched + committed; on flush it is DEPTH.
  - Pointers wrap modulo DEPTH via natural clog2 overflow.
  - Full: num_free=0. Empty: num_free=DEPTH, with no commit.
- Reset mid-operation: all state is discarded immediately and asynchronously; no commit or flush is emitted.

Decomposition:
- Package rob_pkg holds:
  - rob_entry_t (packed);
  - index/count width localparams derived from DEPTH, PRF, AREGS;
  - the mispredict-compare function.
- Sub-module rob_commit_sel:
  - combinational WAYS-window scan producing commit_valid, the retire count, flush and the flush lane;
  - unit-testable on its own.

Test Plan (DEPTH=8, WAYS=2, CDB_W=2):
- Dispatch 2 groups of 2 after reset -> disp_rob_idx {0,1} then {2,3}; num_free 8->6->4.
- CDB completes idx 1 then idx 0 -> no commit while idx0 is not done; the cycle after idx0 is done, commit_valid=2'b11, commit_old_prn matches dispatch, num_free +2.
- Fill to 8 entries -> disp_ready=0 at num_free=0 and stays 0 in a cycle with 2 commits; it rises the following cycle. Pointer wrap 7->0 is verified.
- Branch at idx 2 (pc=0x100, pred_taken=0) resolves cdb_taken=1, cdb_target=0x200 -> on retirement flush=1, redirect_pc=0x200, younger idx3 is not committed, next cycle num_free=8, disp_rob_idx[0]=0.
- Correctly predicted taken branch (target match) -> retires with flush=0. A not-taken mispredict yields redirect_pc=pc+4.
- reset_n pulsed low mid-burst with 5 entries live -> outputs go to reset values asynchronously before the next clock edge.

Source files
------------

// File: rtl/rob_pkg.sv
// rob_pkg: shared types, widths and branch-resolution helpers for the multi-way ROB
package rob_pkg;

    localparam int XLEN_P  = 32;
    localparam int AREGS_P = 32;
    localparam int PRF_P   = 64;
    localparam int DEPTH_P = 32;

    localparam int ARN_W = $clog2(AREGS_P);
    localparam int PRN_W = $clog2(PRF_P);
    localparam int IDX_W = $clog2(DEPTH_P);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [ARN_W-1:0]  arn;
        logic [PRN_W-1:0]  prn;
        logic [PRN_W-1:0]  old_prn;
        logic              reg_write;
        logic              is_branch;
        logic              pred_taken;
        logic [XLEN_P-1:0] pc;
        logic [XLEN_P-1:0] pred_target;
        logic [XLEN_P-1:0] res_target;
        logic              mispred;
    } rob_entry_t;

    function automatic logic is_mispred(input logic pred_taken, input logic taken,
                                        input logic [XLEN_P-1:0] pred_target,
                                        input logic [XLEN_P-1:0] target);
        return (taken != pred_taken) || (taken && (target != pred_target));
    endfunction

    function automatic logic [XLEN_P-1:0] resolved_target(input logic taken,
                                                          input logic [XLEN_P-1:0] target,
                                                          input logic [XLEN_P-1:0] pc);
        return taken ? target : pc + XLEN_P'(4);
    endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// rob_commit_sel: in-order retire scan over the oldest WAYS ROB entries
module rob_commit_sel #(
    parameter  int WAYS = 2,
    localparam int RW   = $clog2(WAYS + 1),
    localparam int LW   = WAYS > 1 ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0] valid,
    input  logic [WAYS-1:0] done,
    input  logic [WAYS-1:0] mispred,
    output logic [WAYS-1:0] retire,
    output logic [RW-1:0]   count,
    output logic            flush,
    output logic [LW-1:0]   flush_lane
);

    // Retire a prefix of completed entries, stopping after the first mispredicted branch
    always_comb begin
        logic go;
        retire     = '0;
        count      = '0;
        flush      = 1'b0;
        flush_lane = '0;
        go         = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            if (go && valid[i] && done[i]) begin
                retire[i] = 1'b1;
                count     = count + RW'(1);
                if (mispred[i]) begin
                    flush      = 1'b1;
                    flush_lane = LW'(i);
                    go         = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_mw.sv
// rob_mw: multi-way reorder buffer with dispatch handshake, CDB completion and mispredict flush
module rob_mw
    import rob_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int CDB_W = 2,
    parameter int DEPTH = 32,
    parameter int XLEN  = XLEN_P,
    parameter int AREGS = AREGS_P,
    parameter int PRF   = PRF_P
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [WAYS-1:0]                        disp_valid,
    output logic                                   disp_ready,
    input  logic [WAYS-1:0][$clog2(AREGS)-1:0]     disp_arn,
    input  logic [WAYS-1:0][$clog2(PRF)-1:0]       disp_prn,
    input  logic [WAYS-1:0][$clog2(PRF)-1:0]       disp_old_prn,
    input  logic [WAYS-1:0]                        disp_reg_write,
    input  logic [WAYS-1:0]                        disp_is_branch,
    input  logic [WAYS-1:0]                        disp_pred_taken,
    input  logic [WAYS-1:0][XLEN-1:0]              disp_pc,
    input  logic [WAYS-1:0][XLEN-1:0]              disp_pred_target,
    output logic [WAYS-1:0][$clog2(DEPTH)-1:0]     disp_rob_idx,
    input  logic [CDB_W-1:0]                       cdb_valid,
    input  logic [CDB_W-1:0]                       cdb_taken,
    input  logic [CDB_W-1:0][$clog2(DEPTH)-1:0]    cdb_rob_idx,
    input  logic [CDB_W-1:0][XLEN-1:0]             cdb_target,
    output logic [WAYS-1:0]                        commit_valid,
    output logic [WAYS-1:0]                        commit_reg_write,
    output logic [WAYS-1:0][$clog2(AREGS)-1:0]     commit_arn,
    output logic [WAYS-1:0][$clog2(PRF)-1:0]       commit_prn,
    output logic [WAYS-1:0][$clog2(PRF)-1:0]       commit_old_prn,
    output logic                                   flush,
    output logic [XLEN-1:0]                        redirect_pc,
    output logic [$clog2(DEPTH):0]                 num_free
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int RW = $clog2(WAYS + 1);
    localparam int LW = WAYS > 1 ? $clog2(WAYS) : 1;

    rob_entry_t            ent [DEPTH];
    logic [IW-1:0]         head;
    logic [IW-1:0]         tail;
    logic [WAYS-1:0][IW-1:0] win_idx;
    logic [WAYS-1:0]       win_valid;
    logic [WAYS-1:0]       win_done;
    logic [WAYS-1:0]       win_mispred;
    logic [RW-1:0]         retire_cnt;
    logic [RW-1:0]         disp_cnt;
    logic [RW-1:0]         acc_cnt;
    logic [LW-1:0]         flush_lane;

    // Slot numbers of the commit window and of the dispatch lanes
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            win_idx[i]      = head + IW'(i);
            disp_rob_idx[i] = tail + IW'(i);
        end
    end

    // Expose the oldest entries to the retire scan and drive the per-lane commit fields
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            win_valid[i]        = ent[win_idx[i]].valid;
            win_done[i]         = ent[win_idx[i]].done;
            win_mispred[i]      = ent[win_idx[i]].mispred;
            commit_reg_write[i] = commit_valid[i] & ent[win_idx[i]].reg_write;
            commit_arn[i]       = ent[win_idx[i]].arn;
            commit_prn[i]       = ent[win_idx[i]].prn;
            commit_old_prn[i]   = ent[win_idx[i]].old_prn;
        end
    end

    // Dispatch group size (lanes are contiguous from lane 0) and the accepted share of it
    always_comb begin
        disp_cnt = '0;
        for (int i = 0; i < WAYS; i++)
            disp_cnt = disp_cnt + RW'(disp_valid[i]);
        disp_ready  = (num_free >= CW'(WAYS)) && !flush;
        acc_cnt     = disp_ready ? disp_cnt : '0;
        redirect_pc = flush ? ent[win_idx[flush_lane]].res_target : '0;
    end

    rob_commit_sel #(.WAYS(WAYS)) u_commit_sel (
        .valid      (win_valid),
        .done       (win_done),
        .mispred    (win_mispred),
        .retire     (commit_valid),
        .count      (retire_cnt),
        .flush      (flush),
        .flush_lane (flush_lane)
    );

    // Entry array and pointers: retire, complete, allocate; flush or reset empties the ROB
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head     <= '0;
            tail     <= '0;
            num_free <= CW'(DEPTH);
            for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            num_free <= CW'(DEPTH);
            for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (commit_valid[i]) begin
                    ent[win_idx[i]].valid <= 1'b0;
                    ent[win_idx[i]].done  <= 1'b0;
                end
            end
            for (int c = 0; c < CDB_W; c++) begin
                if (cdb_valid[c] && ent[cdb_rob_idx[c]].valid) begin
                    ent[cdb_rob_idx[c]].done <= 1'b1;
                    if (ent[cdb_rob_idx[c]].is_branch) begin
                        ent[cdb_rob_idx[c]].mispred <= is_mispred(ent[cdb_rob_idx[c]].pred_taken,
                            cdb_taken[c], ent[cdb_rob_idx[c]].pred_target, cdb_target[c]);
                        ent[cdb_rob_idx[c]].res_target <= resolved_target(cdb_taken[c],
                            cdb_target[c], ent[cdb_rob_idx[c]].pc);
                    end
                end
            end
            if (disp_ready) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (disp_valid[i])
                        ent[tail + IW'(i)] <= '{valid: 1'b1, done: 1'b0, arn: disp_arn[i],
                            prn: disp_prn[i], old_prn: disp_old_prn[i],
                            reg_write: disp_reg_write[i], is_branch: disp_is_branch[i],
                            pred_taken: disp_pred_taken[i], pc: disp_pc[i],
                            pred_target: disp_pred_target[i], res_target: '0, mispred: 1'b0};
                end
            end
            head     <= head + IW'(retire_cnt);
            tail     <= tail + IW'(acc_cnt);
            num_free <= num_free - CW'(acc_cnt) + CW'(retire_cnt);
        end
    end

endmodule

// File: tb/tb_rob_mw.sv
// tb_rob_mw: directed stimulus against a queue-based ROB model plus hand-computed pins
module tb_rob_mw;

    localparam int D = 8;
    localparam int W = 2;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       disp_valid;
    logic             disp_ready;
    logic [1:0][4:0]  disp_arn;
    logic [1:0][5:0]  disp_prn, disp_old_prn;
    logic [1:0]       disp_reg_write, disp_is_branch, disp_pred_taken;
    logic [1:0][31:0] disp_pc, disp_pred_target;
    logic [1:0][2:0]  disp_rob_idx;
    logic [1:0]       cdb_valid, cdb_taken;
    logic [1:0][2:0]  cdb_rob_idx;
    logic [1:0][31:0] cdb_target;
    logic [1:0]       commit_valid, commit_reg_write;
    logic [1:0][4:0]  commit_arn;
    logic [1:0][5:0]  commit_prn, commit_old_prn;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic [3:0]       num_free;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          idx;
        logic [4:0]  arn;
        logic [5:0]  prn, old;
        logic        rw, br, pt, done, mis;
        logic [31:0] pc, ptgt, rtgt;
    } ment_t;

    ment_t mq[$];
    int    mtail = 0;

    rob_mw #(.WAYS(W), .CDB_W(2), .DEPTH(D)) dut (
        .clock(clock), .reset_n(reset_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_arn(disp_arn), .disp_prn(disp_prn), .disp_old_prn(disp_old_prn),
        .disp_reg_write(disp_reg_write), .disp_is_branch(disp_is_branch),
        .disp_pred_taken(disp_pred_taken), .disp_pc(disp_pc),
        .disp_pred_target(disp_pred_target), .disp_rob_idx(disp_rob_idx),
        .cdb_valid(cdb_valid), .cdb_taken(cdb_taken), .cdb_rob_idx(cdb_rob_idx),
        .cdb_target(cdb_target), .commit_valid(commit_valid),
        .commit_reg_write(commit_reg_write), .commit_arn(commit_arn),
        .commit_prn(commit_prn), .commit_old_prn(commit_old_prn),
        .flush(flush), .redirect_pc(redirect_pc), .num_free(num_free)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every falling edge: compare outputs with the model, then advance the model past the next rising edge
    always @(negedge clock) begin
        logic [1:0]  ecv, erw;
        logic        ef, er;
        logic [31:0] ered;
        int          nret, fr;
        ment_t       e;
        if (!reset_n) begin
            mq.delete();
            mtail = 0;
            chk("rst_commit_valid", 64'(commit_valid), 64'(0));
            chk("rst_flush", 64'(flush), 64'(0));
            chk("rst_redirect_pc", 64'(redirect_pc), 64'(0));
            chk("rst_num_free", 64'(num_free), 64'(D));
        end else begin
            ecv = '0; erw = '0; ef = 1'b0; ered = '0; nret = 0;
            for (int k = 0; k < W && k < mq.size(); k++) begin
                if (ef || !mq[k].done) break;
                ecv[k] = 1'b1;
                erw[k] = mq[k].rw;
                nret++;
                if (mq[k].mis) begin
                    ef = 1'b1;
                    ered = mq[k].rtgt;
                end
            end
            fr = D - mq.size();
            er = (fr >= W) && !ef;
            chk("num_free", 64'(num_free), 64'(fr));
            chk("disp_ready", 64'(disp_ready), 64'(er));
            for (int k = 0; k < W; k++)
                chk($sformatf("disp_rob_idx%0d", k), 64'(disp_rob_idx[k]), 64'((mtail + k) % D));
            chk("commit_valid", 64'(commit_valid), 64'(ecv));
            chk("commit_reg_write", 64'(commit_reg_write), 64'(erw));
            chk("flush", 64'(flush), 64'(ef));
            if (ef) chk("redirect_pc", 64'(redirect_pc), 64'(ered));
            for (int k = 0; k < W; k++) begin
                if (ecv[k]) begin
                    chk($sformatf("commit_arn%0d", k), 64'(commit_arn[k]), 64'(mq[k].arn));
                    chk($sformatf("commit_prn%0d", k), 64'(commit_prn[k]), 64'(mq[k].prn));
                    chk($sformatf("commit_old_prn%0d", k), 64'(commit_old_prn[k]), 64'(mq[k].old));
                end
            end
            if (ef) begin
                mq.delete();
                mtail = 0;
            end else begin
                repeat (nret) void'(mq.pop_front());
                for (int c = 0; c < 2; c++) begin
                    if (cdb_valid[c]) begin
                        for (int j = 0; j < mq.size(); j++) begin
                            if (mq[j].idx == int'(cdb_rob_idx[c])) begin
                                mq[j].done = 1'b1;
                                if (mq[j].br) begin
                                    mq[j].mis  = (cdb_taken[c] != mq[j].pt) ||
                                                 (cdb_taken[c] && cdb_target[c] != mq[j].ptgt);
                                    mq[j].rtgt = cdb_taken[c] ? cdb_target[c] : mq[j].pc + 32'd4;
                                end
                            end
                        end
                    end
                end
                if (er) begin
                    for (int i = 0; i < W; i++) begin
                        if (disp_valid[i]) begin
                            e.idx = mtail; e.arn = disp_arn[i]; e.prn = disp_prn[i];
                            e.old = disp_old_prn[i]; e.rw = disp_reg_write[i];
                            e.br = disp_is_branch[i]; e.pt = disp_pred_taken[i];
                            e.pc = disp_pc[i]; e.ptgt = disp_pred_target[i];
                            e.done = 1'b0; e.mis = 1'b0; e.rtgt = '0;
                            mq.push_back(e);
                            mtail = (mtail + 1) % D;
                        end
                    end
                end
            end
        end
    end

    task automatic idle();
        disp_valid = '0; disp_arn = '0; disp_prn = '0; disp_old_prn = '0;
        disp_reg_write = '0; disp_is_branch = '0; disp_pred_taken = '0;
        disp_pc = '0; disp_pred_target = '0;
        cdb_valid = '0; cdb_taken = '0; cdb_rob_idx = '0; cdb_target = '0;
    endtask

    task automatic dl(input int i, input int arn, input int prn, input int old,
                      input int br, input int pt, input int pc, input int ptgt);
        disp_valid[i]       = 1'b1;
        disp_arn[i]         = 5'(arn);
        disp_prn[i]         = 6'(prn);
        disp_old_prn[i]     = 6'(old);
        disp_reg_write[i]   = (br == 0);
        disp_is_branch[i]   = (br != 0);
        disp_pred_taken[i]  = (pt != 0);
        disp_pc[i]          = pc;
        disp_pred_target[i] = ptgt;
    endtask

    task automatic cl(input int c, input int idx, input int tk, input int tgt);
        cdb_valid[c]   = 1'b1;
        cdb_rob_idx[c] = 3'(idx);
        cdb_taken[c]   = (tk != 0);
        cdb_target[c]  = tgt;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clock);
        #1;
        chk("lit_rst_nfree", 64'(num_free), 64'(8));
        chk("lit_rst_cv", 64'(commit_valid), 64'(0));
        reset_n = 1'b1;
        #1;
        chk("lit_ready_after_rst", 64'(disp_ready), 64'(1));
        chk("lit_idx0_first", 64'(disp_rob_idx[0]), 64'(0));
        chk("lit_idx1_first", 64'(disp_rob_idx[1]), 64'(1));
        // two dispatch groups
        dl(0, 1, 33, 1, 0, 0, 'h10, 0); dl(1, 2, 34, 2, 0, 0, 'h14, 0); tick();
        chk("lit_nfree_6", 64'(num_free), 64'(6));
        chk("lit_idx0_g2", 64'(disp_rob_idx[0]), 64'(2));
        dl(0, 3, 35, 3, 0, 0, 'h18, 0); dl(1, 4, 36, 4, 0, 0, 'h1c, 0); tick();
        chk("lit_nfree_4", 64'(num_free), 64'(4));
        // out-of-order completion
        cl(0, 1, 0, 0); tick();
        chk("lit_no_commit_idx0_pending", 64'(commit_valid), 64'(0));
        cl(0, 0, 0, 0); tick();
        chk("lit_cv_11", 64'(commit_valid), 64'(3));
        chk("lit_old_prn0", 64'(commit_old_prn[0]), 64'(1));
        chk("lit_old_prn1", 64'(commit_old_prn[1]), 64'(2));
        tick();
        chk("lit_nfree_back_6", 64'(num_free), 64'(6));
        // fill to full with pointer wrap
        dl(0, 5, 37, 5, 0, 0, 'h20, 0); dl(1, 6, 38, 6, 0, 0, 'h24, 0); tick();
        dl(0, 7, 39, 7, 0, 0, 'h28, 0); dl(1, 8, 40, 8, 0, 0, 'h2c, 0); tick();
        chk("lit_nfree_2", 64'(num_free), 64'(2));
        chk("lit_wrap_idx0", 64'(disp_rob_idx[0]), 64'(0));
        chk("lit_wrap_idx1", 64'(disp_rob_idx[1]), 64'(1));
        dl(0, 9, 41, 9, 0, 0, 'h30, 0); dl(1, 10, 42, 10, 0, 0, 'h34, 0); tick();
        chk("lit_full_nfree", 64'(num_free), 64'(0));
        chk("lit_full_ready", 64'(disp_ready), 64'(0));
        cl(0, 2, 0, 0); cl(1, 3, 0, 0); tick();
        chk("lit_full_cv", 64'(commit_valid), 64'(3));
        chk("lit_full_arn0", 64'(commit_arn[0]), 64'(3));
        chk("lit_ready_0_with_commits", 64'(disp_ready), 64'(0));
        dl(0, 11, 43, 11, 0, 0, 'h38, 0); dl(1, 12, 44, 12, 0, 0, 'h3c, 0); tick();
        chk("lit_ready_rises", 64'(disp_ready), 64'(1));
        chk("lit_nfree_2b", 64'(num_free), 64'(2));
        chk("lit_idx0_2", 64'(disp_rob_idx[0]), 64'(2));
        // mispredicted branch at idx2, younger idx3
        dl(0, 0, 0, 0, 1, 0, 'h100, 'h180); dl(1, 13, 45, 13, 0, 0, 'h104, 0); tick();
        cl(0, 4, 0, 0); cl(1, 5, 0, 0); tick();
        cl(0, 6, 0, 0); cl(1, 7, 0, 0); tick();
        cl(0, 0, 0, 0); cl(1, 1, 0, 0); tick();
        cl(0, 2, 1, 'h200); cl(1, 3, 0, 0); tick();
        chk("lit_flush", 64'(flush), 64'(1));
        chk("lit_redirect_200", 64'(redirect_pc), 64'('h200));
        chk("lit_flush_cv", 64'(commit_valid), 64'(1));
        chk("lit_flush_ready", 64'(disp_ready), 64'(0));
        dl(0, 14, 46, 14, 0, 0, 'h108, 0); cl(0, 3, 0, 0); tick();
        chk("lit_post_flush_nfree", 64'(num_free), 64'(8));
        chk("lit_post_flush_idx0", 64'(disp_rob_idx[0]), 64'(0));
        chk("lit_post_flush_flush", 64'(flush), 64'(0));
        // correct taken branch then not-taken mispredict
        dl(0, 0, 0, 0, 1, 1, 'h300, 'h340); dl(1, 0, 0, 0, 1, 1, 'h400, 'h480); tick();
        cl(0, 0, 1, 'h340); tick();
        chk("lit_good_br_cv", 64'(commit_valid), 64'(1));
        chk("lit_good_br_flush", 64'(flush), 64'(0));
        cl(0, 1, 0, 'h123); tick();
        chk("lit_nt_flush", 64'(flush), 64'(1));
        chk("lit_nt_redirect", 64'(redirect_pc), 64'('h404));
        tick();
        chk("lit_nt_nfree", 64'(num_free), 64'(8));
        // CDB to an invalid entry, then two lanes on one index
        dl(0, 0, 0, 0, 1, 0, 'h500, 'h504); tick();
        cl(0, 5, 1, 'h777); tick();
        chk("lit_invalid_cdb_cv", 64'(commit_valid), 64'(0));
        cl(0, 0, 1, 'h600); cl(1, 0, 0, 0); tick();
        chk("lit_same_idx_cv", 64'(commit_valid), 64'(1));
        chk("lit_same_idx_flush", 64'(flush), 64'(0));
        tick();
        // async reset with five live entries
        dl(0, 15, 47, 15, 0, 0, 'h600, 0); dl(1, 16, 48, 16, 0, 0, 'h604, 0); tick();
        dl(0, 17, 49, 17, 0, 0, 'h608, 0); dl(1, 18, 50, 18, 0, 0, 'h60c, 0); tick();
        dl(0, 19, 51, 19, 0, 0, 'h610, 0); tick();
        chk("lit_five_live", 64'(num_free), 64'(3));
        cl(0, 1, 0, 0); cl(1, 2, 0, 0); tick();
        chk("lit_pre_rst_cv", 64'(commit_valid), 64'(3));
        reset_n = 1'b0;
        #1;
        chk("lit_async_cv", 64'(commit_valid), 64'(0));
        chk("lit_async_nfree", 64'(num_free), 64'(8));
        chk("lit_async_flush", 64'(flush), 64'(0));
        chk("lit_async_idx0", 64'(disp_rob_idx[0]), 64'(0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        dl(0, 20, 52, 20, 0, 0, 'h700, 0); dl(1, 21, 53, 21, 0, 0, 'h704, 0); tick();
        chk("lit_after_rst_nfree", 64'(num_free), 64'(6));
        chk("lit_after_rst_idx0", 64'(disp_rob_idx[0]), 64'(2));
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
